// File: rtl/cpu_core_mc_if.sv
// Instruction-in and result-out valid/ready streams of cpu_core_mc.
// master is the program source / result sink side, slave is the core side.
interface cpu_core_mc_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] ins_data;
   logic              ins_valid;
   logic              ins_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output ins_data, ins_valid, out_ready,
      input  ins_ready, out_data, out_valid
   );

   modport slave (
      input  ins_data, ins_valid, out_ready,
      output ins_ready, out_data, out_valid
   );
endinterface

// File: rtl/cpu_core_mc.sv
// Multicycle four-register CPU core with Z/C flags, conditional jump and halt.
// Optional feature: define CPU_MUL_EN to enable opcode D as MUL rd,rs.
module cpu_core_mc #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   cpu_core_mc_if.slave    bus,
   output logic [PC_W-1:0] pc,
   output logic            invalid,
   output logic            halted,
   output logic            flag_z,
   output logic            flag_c
);

   typedef enum logic [1:0] {S_FETCH, S_IMM, S_EXEC, S_HALT} state_e;
   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_ADDI, OP_JMP, OP_JZ, OP_MUL, OP_OUT, OP_HLT
   } op_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic              z_q, z_d, c_q, c_d;

   op_e               op, fetch_op;
   logic [1:0]        rd, rs;
   logic [DATA_W-1:0] opa, opb, alu_res;
   logic [DATA_W:0]   sum, diff;
   logic              alu_c, alu_wr, op_defined;

   assign op       = op_e'(ir_q[7:4]);
   assign rd       = ir_q[3:2];
   assign rs       = ir_q[1:0];
   assign fetch_op = op_e'(bus.ins_data[7:4]);
   assign opa      = regs_q[rd];
   assign opb      = (op == OP_ADDI) ? imm_q : regs_q[rs];
   assign sum      = {1'b0, opa} + {1'b0, opb};
   assign diff     = {1'b0, opa} - {1'b0, opb};

`ifdef CPU_MUL_EN
   logic [2*DATA_W-1:0] prod;
   assign prod       = {{DATA_W{1'b0}}, opa} * {{DATA_W{1'b0}}, opb};
   assign op_defined = 1'b1;
`else
   assign op_defined = (op != OP_MUL);
`endif

   // Flag-writing ops: result goes to rd, Z from result, C from alu_c.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_wr  = 1'b1;
      case (op)
         OP_ADD, OP_ADDI: {alu_c, alu_res} = sum;
         OP_SUB:          {alu_c, alu_res} = diff;
         OP_AND:          alu_res = opa & opb;
         OP_OR:           alu_res = opa | opb;
         OP_XOR:          alu_res = opa ^ opb;
         OP_SHL: begin
            alu_res = {opa[DATA_W-2:0], 1'b0};
            alu_c   = opa[DATA_W-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, opa[DATA_W-1:1]};
            alu_c   = opa[0];
         end
`ifdef CPU_MUL_EN
         OP_MUL: begin
            alu_res = prod[DATA_W-1:0];
            alu_c   = |prod[2*DATA_W-1:DATA_W];
         end
`endif
         default: alu_wr = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      imm_d      = imm_q;
      out_data_d = out_data_q;
      regs_d     = regs_q;
      z_d        = z_q;
      c_d        = c_q;
      case (state_q)
         S_FETCH: if (bus.ins_valid) begin
            ir_d = bus.ins_data[7:0];
            pc_d = pc_q + PC_W'(1);
            // No write can land between this fetch and the OUT's EXEC, so
            // latching R[rd] here gives a registered, stable out_data.
            if (fetch_op == OP_OUT) out_data_d = regs_q[bus.ins_data[3:2]];
            if (fetch_op inside {OP_LDI, OP_ADDI, OP_JMP, OP_JZ}) state_d = S_IMM;
            else                                                  state_d = S_EXEC;
         end
         S_IMM: if (bus.ins_valid) begin
            imm_d   = bus.ins_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (alu_wr) begin
               regs_d[rd] = alu_res;
               z_d        = (alu_res == '0);
               c_d        = alu_c;
            end
            case (op)
               OP_LDI:  regs_d[rd] = imm_q;
               OP_MOV:  regs_d[rd] = regs_q[rs];
               OP_JMP:  pc_d = imm_q[PC_W-1:0];
               OP_JZ:   if (z_q) pc_d = imm_q[PC_W-1:0];
               OP_OUT:  if (!bus.out_ready) state_d = S_EXEC;
               OP_HLT:  state_d = S_HALT;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= '0;
         ir_q       <= '0;
         imm_q      <= '0;
         out_data_q <= '0;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         imm_q      <= imm_d;
         out_data_q <= out_data_d;
         z_q        <= z_d;
         c_q        <= c_d;
         regs_q     <= regs_d;
      end
   end

   assign bus.ins_ready = (state_q == S_FETCH) || (state_q == S_IMM);
   assign bus.out_valid = (state_q == S_EXEC) && (op == OP_OUT);
   assign bus.out_data  = out_data_q;
   assign pc            = pc_q;
   assign halted        = (state_q == S_HALT);
   assign invalid       = (state_q == S_EXEC) && !op_defined;
   assign flag_z        = z_q;
   assign flag_c        = c_q;

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed-vector bench for cpu_core_mc: programs are fed word by word and
// results observed on the out stream, pc and flag pins.
module tb_cpu_core_mc;
   localparam int DATA_W = 8;
   localparam int PC_W   = 6;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic [PC_W-1:0] pc;
   logic            invalid, halted, flag_z, flag_c;

   cpu_core_mc_if #(.DATA_W(DATA_W)) bus ();

   cpu_core_mc #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .pc(pc), .invalid(invalid),
      .halted(halted), .flag_z(flag_z), .flag_c(flag_c)
   );

   always #5 clk = ~clk;

   int              n_vec   = 0;
   int              n_err   = 0;
   int              out_cnt = 0;
   int              exp_cnt = 0;
   logic [7:0]      last_out = '0;
   logic [PC_W-1:0] exp_pc   = '0;

   // A transfer completes at the posedge following a negedge with valid & ready.
   always @(negedge clk) begin
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         out_cnt++;
         last_out = bus.out_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] w);
      int unsigned n = 0;
      bus.ins_data  = w;
      bus.ins_valid = 1'b1;
      while (!bus.ins_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ins_ready_wait", 32'(bus.ins_ready), 32'd1);
      @(negedge clk);
      bus.ins_valid = 1'b0;
      exp_pc = exp_pc + PC_W'(1);
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   task automatic out_word(input logic [7:0] w, input logic [7:0] exp);
      send(w);
      check("out_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      exp_cnt++;
      check("out_count", 32'(out_cnt), 32'(exp_cnt));
      check("out_data", 32'(last_out), 32'(exp));
   endtask

   task automatic check_flags(input string tag, input logic z, input logic c);
      check({tag, "_z"}, 32'(flag_z), 32'(z));
      check({tag, "_c"}, 32'(flag_c), 32'(c));
   endtask

   initial begin
      logic [PC_W-1:0] hpc;
      bus.ins_data  = '0;
      bus.ins_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);

      check("rst_pc", 32'(pc), 32'd0);
      check("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_invalid", 32'(invalid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check_flags("rst", 1'b0, 1'b0);
      rst_n = 1'b1;

      // LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0
      send(8'h10); send(8'h05); send(8'h14); send(8'h03); send(8'h31);
      idle();
      check_flags("add", 1'b0, 1'b0);
      out_word(8'hE0, 8'h08);
      check("pc_after_out", 32'(pc), 32'd6);

      // LDI R2,FF; ADDI R2,1; JZ 0x20 (taken)
      send(8'h18); send(8'hFF); send(8'hA8); send(8'h01); send(8'hC0); send(8'h20);
      exp_pc = 6'h20;
      idle();
      check("jz_taken_pc", 32'(pc), 32'h20);
      check_flags("addi_wrap", 1'b1, 1'b1);
      out_word(8'hE8, 8'h00);

      // OUT R0 with sink stalled for 5 cycles
      bus.out_ready = 1'b0;
      send(8'hE0);
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", 32'(bus.out_valid), 32'd1);
         check("stall_out_data", 32'(bus.out_data), 32'h08);
         check("stall_ins_ready", 32'(bus.ins_ready), 32'd0);
         @(negedge clk);
      end
      check("stall_no_xfer", 32'(out_cnt), 32'(exp_cnt));
      bus.out_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      check("release_xfer", 32'(out_cnt), 32'(exp_cnt));
      @(negedge clk);
      check("release_single", 32'(out_cnt), 32'(exp_cnt));
      check("release_out_data", 32'(last_out), 32'h08);

      // LDI R3,5A with ins_valid toggling every cycle
      bus.ins_data = 8'h1C; bus.ins_valid = 1'b1; @(negedge clk);
      bus.ins_data = 8'h5A; bus.ins_valid = 1'b0;
      check("tog_pc1", 32'(pc), 32'(exp_pc + PC_W'(1)));
      check("tog_ready_imm", 32'(bus.ins_ready), 32'd1);
      @(negedge clk);
      bus.ins_valid = 1'b1;
      check("tog_pc_gap", 32'(pc), 32'(exp_pc + PC_W'(1)));
      @(negedge clk);
      bus.ins_valid = 1'b0;
      check("tog_pc2", 32'(pc), 32'(exp_pc + PC_W'(2)));
      check("tog_ready_exec", 32'(bus.ins_ready), 32'd0);
      @(negedge clk);
      exp_pc = exp_pc + PC_W'(2);
      out_word(8'hEC, 8'h5A);

      // SUB R1,R0 borrows; XOR clears C; SHL shifts out MSB
      send(8'h44); idle();
      check_flags("sub", 1'b0, 1'b1);
      out_word(8'hE4, 8'hFB);
      send(8'h75); idle();
      check_flags("xor", 1'b1, 1'b0);
      send(8'h18); send(8'h81); send(8'h88); idle();
      check_flags("shl", 1'b0, 1'b1);
      out_word(8'hE8, 8'h02);

      // JZ not taken, JMP to last address, NOP wraps pc
      send(8'hC0); send(8'h05); idle();
      check("jz_not_taken_pc", 32'(pc), 32'(exp_pc));
      send(8'hB0); send(8'h3F); exp_pc = 6'h3F; idle();
      check("jmp_pc", 32'(pc), 32'h3F);
      send(8'h00); idle();
      check("pc_wrap", 32'(pc), 32'd0);
      check_flags("jumps_keep", 1'b0, 1'b1);

`ifdef CPU_MUL_EN
      send(8'h10); send(8'h10); send(8'h14); send(8'h20); send(8'hD1);
      check("mul_invalid", 32'(invalid), 32'd0);
      idle();
      check_flags("mul", 1'b1, 1'b1);
      out_word(8'hE0, 8'h00);
`else
      send(8'hD0);
      check("undef_invalid", 32'(invalid), 32'd1);
      check("undef_pc", 32'(pc), 32'(exp_pc));
      idle();
      check("undef_pulse_end", 32'(invalid), 32'd0);
      check_flags("undef", 1'b0, 1'b1);
      out_word(8'hE0, 8'h08);
`endif

      // HLT then keep offering words
      send(8'hF0); idle();
      hpc = exp_pc;
      bus.ins_data  = 8'h10;
      bus.ins_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("halt_halted", 32'(halted), 32'd1);
         check("halt_ins_ready", 32'(bus.ins_ready), 32'd0);
         check("halt_pc", 32'(pc), 32'(hpc));
      end
      #3 rst_n = 1'b0;
      #1;
      check("arst_pc", 32'(pc), 32'd0);
      check("arst_halted", 32'(halted), 32'd0);
      check("arst_ins_ready", 32'(bus.ins_ready), 32'd1);
      check("arst_out_data", 32'(bus.out_data), 32'd0);
      check_flags("arst", 1'b0, 1'b0);
      bus.ins_valid = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = '0;
      out_word(8'hEC, 8'h00);

      // Reset while an OUT is pending
      bus.out_ready = 1'b0;
      send(8'hE4);
      check("pend_out_valid", 32'(bus.out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("pend_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("pend_rst_ins_ready", 32'(bus.ins_ready), 32'd1);
      check("pend_rst_pc", 32'(pc), 32'd0);
      bus.out_ready = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
